// File: rtl/ann_dense_layer_if.sv
// Sequencer-to-core bus for the dense output layer: strobes, the shared
// data bus and the accumulator / classification results.
interface ann_dense_layer_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
);
    logic              rst_sum;
    logic              ld_in;
    logic              ld_weight;
    logic              ld_multiplication;
    logic              shift_in;
    logic              change;
    logic              ld_bias_LSB;
    logic              ld_bias_MSB;
    logic              bias_addition;
    logic              ReLU_computation;
    logic              ld_max_func;
    logic [3:0]        ld_neuron;
    logic [DATA_W-1:0] in;
    logic [ACC_W-1:0]  acc_out;
    logic [3:0]        class_idx;
    logic [ACC_W-1:0]  class_val;
    logic              class_valid;

    // Sequencer side: drives every strobe and the data bus.
    modport master (
        output rst_sum, ld_in, ld_weight, ld_multiplication, shift_in, change,
               ld_bias_LSB, ld_bias_MSB, bias_addition, ReLU_computation,
               ld_max_func, ld_neuron, in,
        input  acc_out, class_idx, class_val, class_valid
    );

    // Core side.
    modport slave (
        input  rst_sum, ld_in, ld_weight, ld_multiplication, shift_in, change,
               ld_bias_LSB, ld_bias_MSB, bias_addition, ReLU_computation,
               ld_max_func, ld_neuron, in,
        output acc_out, class_idx, class_val, class_valid
    );
endinterface

// File: rtl/ann_dense_layer_core.sv
// Fixed-point dense output layer: rotating Q8.8 input register, one shared
// 16x16 MAC over streamed weights, bias add, ReLU into a neuron bank, and a
// registered argmax that picks the winning class.
module ann_dense_layer_core #(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32,
    parameter int N_INPUTS  = 32,
    parameter int N_NEURONS = 10
) (
    input logic               clk,
    input logic               rst,
    ann_dense_layer_if.slave  bus
);
    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam int IDX_W = 4;

    // Two-cycle MAC slot: fetch latches the weight, accum adds the product.
    typedef enum logic {PH_FETCH, PH_ACCUM} phase_t;

    logic [N_INPUTS-1:0][DATA_W-1:0]  x;
    logic [DATA_W-1:0]                head;
    logic [DATA_W-1:0]                w_reg;
    logic [ACC_W-1:0]                 acc;
    logic [ACC_W-1:0]                 bias;
    logic [CNT_W-1:0]                 wcnt;
    logic [N_NEURONS-1:0][ACC_W-1:0]  neuron;
    phase_t                           phase, phase_nxt;

    logic                             mac_en;
    logic                             w_load;
    logic                             mac_acc;
    logic                             mac_rot;
    logic                             rotate;
    logic signed [2*DATA_W-1:0]       prod_full;
    logic [ACC_W-1:0]                 prod;
    logic [IDX_W-1:0]                 best_idx;
    logic [ACC_W-1:0]                 best_val;
    logic [IDX_W-1:0]                 class_idx;
    logic [ACC_W-1:0]                 class_val;
    logic                             class_valid;

    assign head = x[0];

    // A MAC slot only counts while weights remain; a pending clear wins.
    assign mac_en = bus.ld_weight & bus.ld_multiplication & ~bus.rst_sum
                  & (wcnt < CNT_W'(N_INPUTS));

    // Signed Q8.8 x Q8.8 product, sign-extended into the Q16.16 accumulator.
    assign prod_full = $signed(head) * $signed(w_reg);
    assign prod      = ACC_W'(prod_full);

    // The standalone rotation only applies while the MAC is idle.
    assign rotate = mac_rot | (~bus.ld_multiplication & bus.change);

    // MAC phase register.
    always_ff @(posedge clk) begin
        if (rst || bus.rst_sum) phase <= PH_FETCH;
        else                    phase <= phase_nxt;
    end

    // MAC slot sequencing: weight latch, optional rotation, accumulate.
    always_comb begin
        phase_nxt = phase;
        w_load    = 1'b0;
        mac_acc   = 1'b0;
        mac_rot   = 1'b0;
        if (!bus.ld_multiplication) begin
            phase_nxt = PH_FETCH;
        end else if (mac_en) begin
            case (phase)
                PH_FETCH: begin
                    w_load    = 1'b1;
                    mac_rot   = bus.shift_in;
                    phase_nxt = PH_ACCUM;
                end
                PH_ACCUM: begin
                    mac_acc   = 1'b1;
                    phase_nxt = PH_FETCH;
                end
                default: phase_nxt = PH_FETCH;
            endcase
        end
    end

    // Input register: shift-in of new data beats rotation; x[0] is the head.
    always_ff @(posedge clk) begin
        if (rst)             x <= '0;
        else if (bus.ld_in)  x <= {bus.in, x[N_INPUTS-1:1]};
        else if (rotate)     x <= {x[0], x[N_INPUTS-1:1]};
    end

    // Weight latch, accumulator and weight counter; all adds wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_reg <= '0;
            acc   <= '0;
            wcnt  <= '0;
        end else if (bus.rst_sum) begin
            acc   <= '0;
            wcnt  <= '0;
        end else begin
            if (w_load) w_reg <= bus.in;
            if (mac_acc) begin
                acc  <= acc + prod;
                wcnt <= wcnt + CNT_W'(1);
            end else if (bus.bias_addition) begin
                acc  <= acc + bias;
            end
        end
    end

    // Bias is loaded in two halves from the data bus and survives rst_sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            bias <= '0;
        end else begin
            if (bus.ld_bias_LSB) bias[DATA_W-1:0]     <= bus.in;
            if (bus.ld_bias_MSB) bias[ACC_W-1:DATA_W] <= bus.in;
        end
    end

    // Neuron bank write through ReLU; out-of-range indices are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            neuron <= '0;
        end else if (bus.ReLU_computation && (bus.ld_neuron < IDX_W'(N_NEURONS))) begin
            neuron[bus.ld_neuron] <= acc[ACC_W-1] ? '0 : acc;
        end
    end

    // Argmax over the bank; strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = neuron[0];
        for (int i = 1; i < N_NEURONS; i++) begin
            if ($signed(neuron[i]) > $signed(best_val)) begin
                best_val = neuron[i];
                best_idx = IDX_W'(i);
            end
        end
    end

    // Classification result, held until reset once computed.
    always_ff @(posedge clk) begin
        if (rst) begin
            class_idx   <= '0;
            class_val   <= '0;
            class_valid <= 1'b0;
        end else if (bus.ld_max_func) begin
            class_idx   <= best_idx;
            class_val   <= best_val;
            class_valid <= 1'b1;
        end
    end

    assign bus.acc_out     = acc;
    assign bus.class_idx   = class_idx;
    assign bus.class_val   = class_val;
    assign bus.class_valid = class_valid;
endmodule

// File: tb/tb_ann_dense_layer_core.sv
// Bench for ann_dense_layer_core: constant vector table, directed multi-cycle
// corner cases, and randomized neurons checked against a dot-product model.
module tb_ann_dense_layer_core;
    localparam int N  = 32;
    localparam int NN = 10;

    typedef struct {
        logic [15:0] x;
        logic [15:0] wt;
        logic [31:0] bias;
        logic [3:0]  idx;
        logic [31:0] exp_pre;
        logic [31:0] exp_post;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ann_dense_layer_if bus ();
    ann_dense_layer_core dut (.clk(clk), .rst(rst), .bus(bus));

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] a [N];
    logic [15:0] w [N];
    logic [31:0] m_bank [NN];
    vec_t        tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rst_sum = 0; bus.ld_in = 0; bus.ld_weight = 0; bus.ld_multiplication = 0;
        bus.shift_in = 0; bus.change = 0; bus.ld_bias_LSB = 0; bus.ld_bias_MSB = 0;
        bus.bias_addition = 0; bus.ReLU_computation = 0; bus.ld_max_func = 0;
        bus.ld_neuron = 0; bus.in = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1; step(); rst = 0;
        for (int i = 0; i < NN; i++) m_bank[i] = 0;
    endtask

    task automatic load_inputs();
        for (int i = 0; i < N; i++) begin
            bus.ld_in = 1; bus.in = a[i]; step();
        end
        bus.ld_in = 0;
    endtask

    // Sequencer MAC: each weight held two cycles, shift_in on slots 1..31,
    // then one change cycle. abort_slot >= 0 hits rst instead of that slot.
    task automatic run_mac(input int abort_slot, input bit extra);
        for (int s = 0; s < N; s++) begin
            if (s == abort_slot) begin
                idle(); rst = 1; step(); rst = 0;
                for (int i = 0; i < NN; i++) m_bank[i] = 0;
                return;
            end
            bus.ld_weight = 1; bus.ld_multiplication = 1;
            bus.shift_in = (s != 0); bus.in = w[s];
            step(); step();
        end
        if (extra) begin
            bus.shift_in = 1; bus.in = 16'h7FFF; step();
        end
        bus.ld_weight = 0; bus.ld_multiplication = 0; bus.shift_in = 0;
        bus.change = 1; step(); bus.change = 0;
    endtask

    task automatic load_bias(input logic [31:0] b);
        bus.ld_bias_LSB = 1; bus.in = b[15:0];  step(); bus.ld_bias_LSB = 0;
        bus.ld_bias_MSB = 1; bus.in = b[31:16]; step(); bus.ld_bias_MSB = 0;
    endtask

    task automatic pulse_bias();  bus.bias_addition = 1; step(); bus.bias_addition = 0; endtask
    task automatic pulse_sum();   bus.rst_sum = 1;       step(); bus.rst_sum = 0;       endtask
    task automatic pulse_max();   bus.ld_max_func = 1;   step(); bus.ld_max_func = 0;   endtask

    task automatic relu(input logic [3:0] idx);
        bus.ReLU_computation = 1; bus.ld_neuron = idx; step();
        bus.ReLU_computation = 0;
    endtask

    // Reference: wrapping signed dot product of the current a[] and w[].
    function automatic logic [31:0] model_dot();
        int s = 0;
        for (int i = 0; i < N; i++) s = s + int'($signed(a[i])) * int'($signed(w[i]));
        return 32'(s);
    endfunction

    function automatic logic [31:0] model_relu(input logic [31:0] v);
        return v[31] ? 32'd0 : v;
    endfunction

    function automatic int model_argmax();
        int best = 0;
        for (int i = 1; i < NN; i++)
            if ($signed(m_bank[i]) > $signed(m_bank[best])) best = i;
        return best;
    endfunction

    task automatic set_neuron(input int k, input logic [31:0] v);
        pulse_sum(); load_bias(v); pulse_bias(); relu(4'(k));
        m_bank[k] = model_relu(v);
    endtask

    initial begin
        logic [31:0] exp_v;
        logic [31:0] rb;
        int          best;
        int          idx;

        tbl[0] = '{16'h0100, 16'h0100, 32'hFFFB5A00, 4'd0, 32'h00200000, 32'h001B5A00};
        tbl[1] = '{16'h0100, 16'hFF00, 32'h00000000, 4'd1, 32'hFFE00000, 32'hFFE00000};
        tbl[2] = '{16'h0200, 16'h0080, 32'h00010000, 4'd2, 32'h00200000, 32'h00210000};
        tbl[3] = '{16'h8000, 16'h8000, 32'h00000000, 4'd3, 32'h00000000, 32'h00000000};
        tbl[4] = '{16'h7FFF, 16'h7FFF, 32'h12345678, 4'd4, 32'hFFE00020, 32'h12145698};

        idle();
        rst = 1;
        step(); step();
        rst = 0;
        check("reset_acc", bus.acc_out, 32'd0);
        check("reset_class_idx", 32'(bus.class_idx), 32'd0);
        check("reset_class_val", bus.class_val, 32'd0);
        check("reset_class_valid", 32'(bus.class_valid), 32'd0);

        // Uniform-pattern table.
        for (int r = 0; r < 5; r++) begin
            pulse_sum();
            for (int i = 0; i < N; i++) begin a[i] = tbl[r].x; w[i] = tbl[r].wt; end
            load_inputs();
            run_mac(-1, 0);
            check($sformatf("tbl%0d_pre_bias", r), bus.acc_out, tbl[r].exp_pre);
            load_bias(tbl[r].bias);
            pulse_bias();
            check($sformatf("tbl%0d_post_bias", r), bus.acc_out, tbl[r].exp_post);
            relu(tbl[r].idx);
        end
        check("tbl_valid_before_max", 32'(bus.class_valid), 32'd0);
        pulse_max();
        check("tbl_class_idx", 32'(bus.class_idx), 32'd4);
        check("tbl_class_val", bus.class_val, 32'h12145698);
        check("tbl_class_valid", 32'(bus.class_valid), 32'd1);

        // Single-weight slot picks a5; second neuron proves the rotation restored.
        pulse_sum();
        check("rst_sum_clears_acc", bus.acc_out, 32'd0);
        for (int i = 0; i < N; i++) begin a[i] = 16'(i * 256); w[i] = 16'h0000; end
        w[5] = 16'h0100;
        load_inputs();
        run_mac(-1, 0);
        check("slot5_first", bus.acc_out, 32'h00050000);
        relu(4'd1);
        pulse_sum();
        run_mac(-1, 0);
        check("slot5_repeat", bus.acc_out, 32'h00050000);
        relu(4'd2);

        // Bank {0,7,3,9,9,0...}: tie on 9 resolves to index 3.
        do_reset();
        set_neuron(0, 32'd0); set_neuron(1, 32'd7); set_neuron(2, 32'd3);
        set_neuron(3, 32'd9); set_neuron(4, 32'd9);
        for (int k = 5; k < NN; k++) set_neuron(k, 32'd0);
        pulse_sum(); load_bias(32'h7FFFFFFF); pulse_bias(); relu(4'd12);
        check("bank_valid_before_max", 32'(bus.class_valid), 32'd0);
        bus.ld_max_func = 1; step(); bus.ld_max_func = 0;
        check("bank_class_valid", 32'(bus.class_valid), 32'd1);
        check("bank_class_idx", 32'(bus.class_idx), 32'd3);
        check("bank_class_val", bus.class_val, 32'd9);
        step(); step();
        check("bank_valid_held", 32'(bus.class_valid), 32'd1);

        // Reset in the middle of the MAC.
        pulse_sum();
        for (int i = 0; i < N; i++) begin a[i] = 16'($urandom); w[i] = 16'h0100; end
        load_inputs();
        run_mac(10, 0);
        check("midmac_rst_acc", bus.acc_out, 32'd0);
        check("midmac_rst_valid", 32'(bus.class_valid), 32'd0);
        check("midmac_rst_class_val", bus.class_val, 32'd0);
        run_mac(-1, 0);
        check("midmac_inputs_cleared", bus.acc_out, 32'd0);
        pulse_sum();
        for (int i = 0; i < N; i++) begin a[i] = 16'($urandom); w[i] = 16'($urandom); end
        load_inputs();
        run_mac(-1, 0);
        check("midmac_fresh_sum", bus.acc_out, model_dot());

        // Extra MAC cycle after the last slot is ignored; change restores a0.
        pulse_sum();
        for (int i = 0; i < N; i++) begin a[i] = 16'($urandom); w[i] = 16'($urandom); end
        load_inputs();
        run_mac(-1, 1);
        check("extra_cycle_acc", bus.acc_out, model_dot());
        pulse_sum();
        for (int i = 0; i < N; i++) w[i] = 16'h0000;
        w[0] = 16'h0100;
        run_mac(-1, 0);
        check("extra_cycle_head_a0", bus.acc_out, model_dot());

        // Randomized neurons against the model.
        do_reset();
        rb = 32'd0;
        for (int it = 0; it < 20; it++) begin
            pulse_sum();
            if (it == 0 || $urandom_range(0, 1) == 1) begin
                for (int i = 0; i < N; i++) a[i] = 16'($urandom);
                load_inputs();
            end
            for (int i = 0; i < N; i++) w[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            run_mac(-1, 0);
            exp_v = model_dot();
            check($sformatf("rand%0d_pre_bias", it), bus.acc_out, exp_v);
            rb = $urandom;
            load_bias(rb);
            pulse_bias();
            exp_v = exp_v + rb;
            check($sformatf("rand%0d_post_bias", it), bus.acc_out, exp_v);
            idx = $urandom_range(0, NN - 1);
            relu(4'(idx));
            m_bank[idx] = model_relu(exp_v);
        end
        pulse_sum();
        pulse_bias();
        check("bias_retained_after_rst_sum", bus.acc_out, rb);
        pulse_max();
        best = model_argmax();
        check("rand_class_idx", 32'(bus.class_idx), 32'(best));
        check("rand_class_val", bus.class_val, m_bank[best]);
        check("rand_class_valid", 32'(bus.class_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
